// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives a req/gnt/rvalid data bus, aligns store lanes, extends load data.
// Optional macro LSU_TIMEOUT_EN adds a REQ/WAIT watchdog that raises bus_err_o.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] op1_add_op2_res_i,
  input  logic [1:0]  mem_raddr_index_i,
  input  logic [1:0]  mem_waddr_index_i,
  input  logic [31:0] reg2_rdata_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] reg_wdata_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic        is_load, is_store, is_mem, misal, go, busy, done_evt, tmo_fire;
  logic [2:0]  f3, f3_q;
  logic [1:0]  idx, idx_q;
  logic [3:0]  st_be;
  logic [31:0] st_wd, ld_ext, ld_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        unused_bits;

  assign unused_bits = ^{inst_i[31:15], inst_i[11:7], op1_add_op2_res_i[1:0]};

  assign f3       = inst_i[14:12];
  assign is_load  = inst_i[6:0] == OP_LOAD;
  assign is_store = inst_i[6:0] == OP_STORE;
  assign is_mem   = is_load | is_store;
  assign idx      = is_store ? mem_waddr_index_i : mem_raddr_index_i;
  assign misal    = (f3[1:0] == 2'b01 && idx[0]) || (f3[1] && idx != 2'b00);
  assign go       = (state == IDLE) && is_mem && !misal;
  assign busy     = (state == REQ) || (state == WAIT);
  assign done_evt = (state == REQ && mem_gnt_i) || (state == WAIT && mem_rvalid_i);

  always_comb begin
    st_be = 4'b1111;
    st_wd = 32'd0;
    if (is_store) begin
      st_wd = reg2_rdata_i;
      case (f3[1:0])
        2'b00: begin st_be = 4'b0001 << idx; st_wd = {4{reg2_rdata_i[7:0]}}; end
        2'b01: begin st_be = 4'b0011 << idx; st_wd = {2{reg2_rdata_i[15:0]}}; end
        default: ;
      endcase
    end
  end

  // Extension uses the offset/type captured at issue; EX/MEM inputs are only trusted for writeback.
  always_comb begin
    ld_b = mem_rdata_i[8*idx_q +: 8];
    ld_h = idx_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_ext = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_ext = {24'd0, ld_b};
      3'b101:  ld_ext = {16'd0, ld_h};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_be_o    <= 4'd0;
      mem_wdata_o <= 32'd0;
      ld_data     <= 32'd0;
      f3_q        <= 3'd0;
      idx_q       <= 2'd0;
    end else begin
      state <= state_nxt;
      if (go) begin
        mem_we_o    <= is_store;
        mem_addr_o  <= {op1_add_op2_res_i[31:2], 2'b00};
        mem_be_o    <= st_be;
        mem_wdata_o <= st_wd;
        f3_q        <= f3;
        idx_q       <= idx;
      end
      if (state == WAIT && mem_rvalid_i) ld_data <= ld_ext;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  assign tmo_fire = busy && !done_evt && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt   <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= tmo_fire;
      if (go)        tmo_cnt <= '0;
      else if (busy) tmo_cnt <= tmo_cnt + CW'(1);
    end
  end
`else
  localparam int unsigned unused_tmo = TIMEOUT_CYCLES;
  assign tmo_fire  = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = REQ;
      REQ:  if (mem_gnt_i) state_nxt = mem_we_o ? DONE : WAIT;
            else if (tmo_fire) state_nxt = DONE;
      WAIT: if (mem_rvalid_i || tmo_fire) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall/misaligned are qualified by reset so a held memory op can't assert them during reset.
  assign mem_req_o    = state == REQ;
  assign stall_o      = rst && (go || busy);
  assign misaligned_o = rst && (state == IDLE) && is_mem && misal;

  always_comb begin
    reg_wdata_o = reg_wdata_i;
    reg_we_o    = reg_we_i;
    reg_waddr_o = reg_waddr_i;
    case (state)
      IDLE: if (is_mem) reg_we_o = 1'b0;
      DONE: begin
        if (!mem_we_o && !bus_err_o) reg_wdata_o = ld_data;
        else                         reg_we_o    = 1'b0;
      end
      default: reg_we_o = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stores, loads, misaligned, reset in flight, optional timeout.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, op1_add_op2_res_i, reg2_rdata_i, reg_wdata_i, mem_rdata_i;
  logic [1:0]  mem_raddr_index_i, mem_waddr_index_i;
  logic        reg_we_i, mem_gnt_i, mem_rvalid_i;
  logic [4:0]  reg_waddr_i;
  logic        mem_req_o, mem_we_o, reg_we_o, stall_o, misaligned_o, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, reg_wdata_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  reg_waddr_o;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  mem_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .op1_add_op2_res_i(op1_add_op2_res_i),
    .mem_raddr_index_i(mem_raddr_index_i), .mem_waddr_index_i(mem_waddr_index_i),
    .reg2_rdata_i(reg2_rdata_i), .reg_wdata_i(reg_wdata_i), .reg_we_i(reg_we_i),
    .reg_waddr_i(reg_waddr_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
    .stall_o(stall_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd);
    inst_i            = {17'd0, f3, 5'd0, op};
    op1_add_op2_res_i = addr;
    mem_raddr_index_i = addr[1:0];
    mem_waddr_index_i = addr[1:0];
    reg2_rdata_i      = rs2;
    reg_wdata_i       = 32'h5555_AAAA;
    reg_we_i          = 1'b1;
    reg_waddr_i       = rd;
  endtask

  // Starts at a negedge with the FSM idle; returns at the negedge of the DONE cycle.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input int gnt_wait);
    set_op(7'b0100011, f3, addr, rs2, 5'd7);
    #1 chk({tag, "_idle_stall"}, 32'(stall_o), 32'd1);
    chk({tag, "_idle_req"}, 32'(mem_req_o), 32'd0);
    for (int i = 0; i <= gnt_wait; i++) begin
      @(negedge clk);
      chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
      chk({tag, "_stall"}, 32'(stall_o), 32'd1);
      if (i == gnt_wait) mem_gnt_i = 1'b1;
    end
    chk({tag, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
    chk({tag, "_be"}, 32'(mem_be_o), 32'(exp_be));
    chk({tag, "_wdata"}, mem_wdata_o, exp_wd);
    chk({tag, "_we"}, 32'(mem_we_o), 32'd1);
    @(negedge clk);
    mem_gnt_i = 1'b0;
    chk({tag, "_done_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_done_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_done_we"}, 32'(reg_we_o), 32'd0);
    inst_i = NOP;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    set_op(7'b0000011, f3, addr, 32'd0, 5'd5);
    #1 chk({tag, "_idle_stall"}, 32'(stall_o), 32'd1);
    @(negedge clk);
    chk({tag, "_req"}, 32'(mem_req_o), 32'd1);
    chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
    chk({tag, "_be"}, 32'(mem_be_o), 32'hF);
    chk({tag, "_addr"}, mem_addr_o, {addr[31:2], 2'b00});
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    chk({tag, "_wait_req"}, 32'(mem_req_o), 32'd0);
    chk({tag, "_wait_stall"}, 32'(stall_o), 32'd1);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'hDEAD_0000;
    chk({tag, "_data"}, reg_wdata_o, exp);
    chk({tag, "_rwe"}, 32'(reg_we_o), 32'd1);
    chk({tag, "_rd"}, 32'(reg_waddr_o), 32'd5);
    chk({tag, "_done_stall"}, 32'(stall_o), 32'd0);
    inst_i = NOP;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    inst_i = NOP; op1_add_op2_res_i = 32'd0; mem_raddr_index_i = 2'd0; mem_waddr_index_i = 2'd0;
    reg2_rdata_i = 32'd0; reg_wdata_i = 32'h0000_1234; reg_we_i = 1'b1; reg_waddr_i = 5'd3;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_be", 32'(mem_be_o), 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_mis", 32'(misaligned_o), 32'd0);
    chk("rst_berr", 32'(bus_err_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("pass_wdata", reg_wdata_o, 32'h0000_1234);
    chk("pass_we", 32'(reg_we_o), 32'd1);
    chk("pass_rd", 32'(reg_waddr_o), 32'd3);
    chk("pass_stall", 32'(stall_o), 32'd0);

    do_store("sw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1);
    @(negedge clk);
    do_store("sb", 3'b000, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 0);
    @(negedge clk);
    do_store("sh", 3'b001, 32'h0000_0402, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 0);
    @(negedge clk);

    do_load("lb",  3'b000, 32'h0000_0202, 32'h12F0_3456, 32'hFFFF_FFF0);
    do_load("lbu", 3'b100, 32'h0000_0202, 32'h12F0_3456, 32'h0000_00F0);
    do_load("lh",  3'b001, 32'h0000_0202, 32'h12F0_3456, 32'h0000_12F0);
    do_load("lhn", 3'b001, 32'h0000_0200, 32'h0000_8001, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0200, 32'h0000_8001, 32'h0000_8001);
    do_load("lb0", 3'b000, 32'h0000_0201, 32'h0000_7F00, 32'h0000_007F);
    do_load("lw",  3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'hCAFE_F00D);

    set_op(7'b0000011, 3'b010, 32'h0000_0101, 32'd0, 5'd9);
    #1 chk("mis_flag", 32'(misaligned_o), 32'd1);
    chk("mis_stall", 32'(stall_o), 32'd0);
    chk("mis_req", 32'(mem_req_o), 32'd0);
    chk("mis_we", 32'(reg_we_o), 32'd0);
    @(negedge clk);
    inst_i = NOP;
    #1 chk("mis_clear", 32'(misaligned_o), 32'd0);
    chk("mis_noreq", 32'(mem_req_o), 32'd0);
    set_op(7'b0100011, 3'b001, 32'h0000_0103, 32'd0, 5'd9);
    #1 chk("mis_sh", 32'(misaligned_o), 32'd1);
    @(negedge clk);
    inst_i = NOP;

    // Reset while waiting on read data: late rvalid and stray gnt must be ignored.
    set_op(7'b0000011, 3'b010, 32'h0000_0200, 32'd0, 5'd6);
    @(negedge clk);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    chk("wr_in_wait", 32'(stall_o), 32'd1);
    rst = 1'b0;
    #1 chk("wr_req", 32'(mem_req_o), 32'd0);
    chk("wr_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    inst_i = NOP; reg_we_i = 1'b1; reg_wdata_i = 32'h0000_0042; reg_waddr_i = 5'd4;
    rst = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111; mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
    chk("wr_post_stall", 32'(stall_o), 32'd0);
    chk("wr_post_req", 32'(mem_req_o), 32'd0);
    chk("wr_post_pass", reg_wdata_o, 32'h0000_0042);
    chk("wr_post_we", 32'(reg_we_o), 32'd1);
    do_store("post_sw", 3'b010, 32'h0000_0500, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, 0);
    @(negedge clk);

`ifdef LSU_TIMEOUT_EN
    begin
      int n;
      set_op(7'b0100011, 3'b010, 32'h0000_0600, 32'h1, 5'd1);
      n = 0;
      @(negedge clk);
      while (mem_req_o && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk("tmo_req_cycles", 32'(n), 32'd16);
      chk("tmo_berr", 32'(bus_err_o), 32'd1);
      chk("tmo_stall", 32'(stall_o), 32'd0);
      chk("tmo_we", 32'(reg_we_o), 32'd0);
      inst_i = NOP;
      @(negedge clk);
      chk("tmo_berr_clr", 32'(bus_err_o), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit of the RV32I pipeline.
- Consumes the EX/MEM pipeline register outputs and issues data-memory transactions on a req/gnt/rvalid bus.
- Byte-aligns store data into a byte-enabled write, and sign- or zero-extends load data.
- Stalls the pipeline until each access completes, then forwards the writeback triple to MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles spent in REQ+WAIT before bus error (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- inst_i  in  32  instruction from EX/MEM
- op1_add_op2_res_i  in  32  effective address
- mem_raddr_index_i  in  2  load byte offset (addr[1:0])
- mem_waddr_index_i  in  2  store byte offset (addr[1:0])
- reg2_rdata_i  in  32  store source data
- reg_wdata_i  in  32  non-load writeback data
- reg_we_i  in  1  writeback enable
- reg_waddr_i  in  5  writeback register
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  write data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data
- reg_wdata_o  out  32  writeback data to MEM/WB
- reg_we_o  out  1  writeback enable to MEM/WB
- reg_waddr_o  out  5  writeback register to MEM/WB
- stall_o  out  1  hold IF..EX/MEM
- misaligned_o  out  1  one-cycle misaligned-access flag
- bus_err_o  out  1  one-cycle bus error (optional feature only, else tied 0)

Behaviour:
- Decode:
  - load = inst_i[6:0]==7'b0000011; store = 7'b0100011; funct3 = inst_i[14:12].
  - Misaligned: halfword with index[0]=1, or word with index!=0.
- Reset (rst=0, async):
  - state=IDLE; mem_req_o, mem_we_o, stall_o, misaligned_o, bus_err_o = 0.
  - mem_addr_o, mem_be_o, mem_wdata_o and the load-data register = 0.
  - A request in flight is abandoned; a later rvalid is ignored.
- IDLE:
  - Non-memory instruction: reg_*_o = reg_*_i combinationally, stall_o=0.
  - Aligned load/store: capture address, be, wdata and extend-type; stall_o=1; next REQ.
  - Misaligned load/store: no bus access; misaligned_o=1 for that cycle; reg_we_o=0; stall_o=0; stay IDLE.
- REQ:
  - mem_req_o=1 with captured fields stable until gnt.
  - On gnt: store -> DONE, load -> WAIT. stall_o=1.
- WAIT:
  - mem_req_o=0. On rvalid, register the extended data -> DONE. stall_o=1.
- DONE:
  - stall_o=0.
  - Load: reg_wdata_o = extended data, reg_we_o = reg_we_i.
  - Store: reg_we_o=0.
  - Next IDLE; EX/MEM advances on this edge.
- Store byte lanes:
  - SB: be = 4'b0001<<idx, wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<idx, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
- Loads: mem_we_o=0, be=4'b1111. Select byte/half by index, then:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - funct3 3'b011/3'b110/3'b111 are treated as LW.
- Timing:
  - gnt in the first REQ cycle gives store latency 3 cycles (IDLE, REQ, DONE).
  - rvalid in the first WAIT cycle gives load latency 4 cycles.
- Bus rules:
  - gnt and rvalid outside REQ/WAIT are ignored.
  - rvalid arriving in REQ (same cycle as gnt) is ignored; the bus guarantees rvalid at least one cycle after gnt.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- When defined:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: drop mem_req_o, pulse bus_err_o for 1 cycle, go to DONE with reg_we_o=0.
- When undefined: no counter; REQ/WAIT wait indefinitely; bus_err_o tied 0.

Test Plan:
- SW: addr 0x100, rs2=0xDEADBEEF, gnt in 2nd REQ cycle -> req held 2 cycles; addr=0x100, be=1111, we=1; stall 3 cycles; reg_we_o=0 in DONE.
- SB: addr 0x103, rs2=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, addr=0x100.
- LB: addr 0x202, rdata=0x12F03456 -> reg_wdata_o=0xFFFFFFF0. LBU, same inputs -> 0x000000F0. LH at 0x202 -> 0x000012F0, reg_we_o=1, rd=5.
- LW at 0x101 -> no req, misaligned_o=1 one cycle, stall_o=0, reg_we_o=0.
- rst driven low while in WAIT -> mem_req_o=0, stall_o=0 immediately; rvalid after release ignored, state IDLE.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, gnt never asserted -> req dropped after 16 cycles, bus_err_o pulses, stall released next cycle.
